// File: rtl/conv_tap_sequencer.sv
// Buffers one kernel window of pixel/weight pairs and streams their signed
// products, each held HOLD cycles. Optional zero-weight skip: CONV_TAP_ZERO_SKIP_EN.
module conv_tap_sequencer #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 9,
  parameter int OUT_W  = 32,
  parameter int HOLD   = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LoadValid,
  input  logic [DATA_W-1:0] LoadPixel,
  input  logic [DATA_W-1:0] LoadWeight,
  output logic              LoadReady,
  output logic              AccumReset,
  output logic [OUT_W-1:0]  ProdOut,
  output logic              ProdValid,
  output logic              WindowDone
);

  localparam int IW = $clog2(TAPS + 1);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DONE
  } state_t;

  state_t state, state_n;

  logic [IW-1:0] lidx;
  logic [IW-1:0] sidx;
  logic [IW-1:0] seek_start;
  logic [IW-1:0] seek_idx;
  logic [IW-1:0] rd_idx;
  logic [HW-1:0] hcnt;
  logic          seek_ok;
  logic          hold_last;
  logic          load_last;
  logic          accept;
  logic          advance;

  logic signed [DATA_W-1:0]   pix [TAPS];
  logic signed [DATA_W-1:0]   wgt [TAPS];
  logic signed [2*DATA_W-1:0] prod;
  logic        [OUT_W-1:0]    prod_ext;

  assign accept     = (state == IDLE) && LoadValid;
  assign load_last  = lidx == IW'(TAPS - 1);
  assign hold_last  = hcnt == HW'(HOLD - 1);
  assign seek_start = (state == CLEAR) ? '0 : sidx + 1'b1;

`ifdef CONV_TAP_ZERO_SKIP_EN
  // Lowest non-zero-weight tap at or after seek_start.
  always_comb begin
    seek_ok  = 1'b0;
    seek_idx = '0;
    for (int i = TAPS - 1; i >= 0; i--) begin
      if (i >= int'(seek_start) && wgt[i] != '0) begin
        seek_ok  = 1'b1;
        seek_idx = IW'(i);
      end
    end
  end
`else
  assign seek_ok  = seek_start < IW'(TAPS);
  assign seek_idx = seek_start;
`endif

  assign rd_idx   = seek_ok ? seek_idx : '0;
  assign prod     = pix[rd_idx] * wgt[rd_idx];
  assign prod_ext = OUT_W'(prod);
  assign advance  = (state == CLEAR) ||
                    ((state == STREAM) && hold_last);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (accept && load_last) state_n = CLEAR;
      CLEAR:  state_n = seek_ok ? STREAM : DONE;
      STREAM: if (hold_last && !seek_ok) state_n = DONE;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      pix[lidx] <= LoadPixel;
      wgt[lidx] <= LoadWeight;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      lidx       <= '0;
      sidx       <= '0;
      hcnt       <= '0;
      LoadReady  <= 1'b1;
      AccumReset <= 1'b0;
      ProdValid  <= 1'b0;
      WindowDone <= 1'b0;
      ProdOut    <= '0;
    end else begin
      state <= state_n;
      if (accept) lidx <= load_last ? '0 : lidx + 1'b1;
      if (state == STREAM && !hold_last) hcnt <= hcnt + 1'b1;
      else hcnt <= '0;
      if (state == DONE) sidx <= '0;
      else if (advance) sidx <= seek_idx;
      // Outputs track the state being entered so they stay registered.
      LoadReady  <= state_n == IDLE;
      AccumReset <= state_n == CLEAR;
      ProdValid  <= state_n == STREAM;
      WindowDone <= state_n == DONE;
      if (state_n != STREAM) ProdOut <= '0;
      else if (advance) ProdOut <= prod_ext;
    end
  end

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Directed + randomized windows against a per-tap product model.
// Optional zero-weight skip follows CONV_TAP_ZERO_SKIP_EN.
module tb_conv_tap_sequencer;

  localparam int DATA_W = 16;
  localparam int TAPS   = 9;
  localparam int OUT_W  = 32;
  localparam int HOLD   = 2;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              LoadValid = 1'b0;
  logic [DATA_W-1:0] LoadPixel = '0;
  logic [DATA_W-1:0] LoadWeight = '0;
  logic              LoadReady;
  logic              AccumReset;
  logic [OUT_W-1:0]  ProdOut;
  logic              ProdValid;
  logic              WindowDone;

  int checks = 0;
  int failures = 0;
  int tp[TAPS];
  int tw[TAPS];

  conv_tap_sequencer #(
    .DATA_W(DATA_W),
    .TAPS(TAPS),
    .OUT_W(OUT_W),
    .HOLD(HOLD)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .LoadValid(LoadValid),
    .LoadPixel(LoadPixel),
    .LoadWeight(LoadWeight),
    .LoadReady(LoadReady),
    .AccumReset(AccumReset),
    .ProdOut(ProdOut),
    .ProdValid(ProdValid),
    .WindowDone(WindowDone)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, ":ready"}, 64'(LoadReady), 64'd1);
    check({tag, ":clr"}, 64'(AccumReset), 64'd0);
    check({tag, ":valid"}, 64'(ProdValid), 64'd0);
    check({tag, ":prod"}, 64'(ProdOut), 64'd0);
    check({tag, ":done"}, 64'(WindowDone), 64'd0);
  endtask

  function automatic int rnd_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic run_window(input string tag, input int abort_at);
    int act[$];
    longint p;
    longint msum;
    longint dsum;
    logic [OUT_W-1:0] e;
    int n;
    msum = 0;
    dsum = 0;
    for (int i = 0; i < TAPS; i++) begin
      repeat ($urandom_range(0, 2)) begin
        LoadValid = 1'b0;
        LoadPixel = DATA_W'($urandom);
        step();
      end
      check({tag, ":ready"}, 64'(LoadReady), 64'd1);
      check({tag, ":clr_early"}, 64'(AccumReset), 64'd0);
      LoadValid  = 1'b1;
      LoadPixel  = DATA_W'(tp[i]);
      LoadWeight = DATA_W'(tw[i]);
      step();
    end
    // Cycle C: keep offering junk, which must be ignored.
    LoadPixel  = DATA_W'($urandom);
    LoadWeight = DATA_W'($urandom);
    check({tag, ":clr"}, 64'(AccumReset), 64'd1);
    check({tag, ":c_valid"}, 64'(ProdValid), 64'd0);
    check({tag, ":c_prod"}, 64'(ProdOut), 64'd0);
    check({tag, ":c_ready"}, 64'(LoadReady), 64'd0);
    for (int k = 0; k < TAPS; k++) begin
`ifdef CONV_TAP_ZERO_SKIP_EN
      if (tw[k] != 0) act.push_back(k);
`else
      act.push_back(k);
`endif
    end
    n = 0;
    foreach (act[j]) begin
      p = longint'(tp[act[j]]) * longint'(tw[act[j]]);
      e = OUT_W'(p);
      msum += p;
      for (int h = 0; h < HOLD; h++) begin
        step();
        n++;
        LoadPixel  = DATA_W'($urandom);
        LoadWeight = DATA_W'($urandom);
        check({tag, ":valid"}, 64'(ProdValid), 64'd1);
        check({tag, ":prod"}, 64'(ProdOut), 64'(e));
        check({tag, ":s_clr"}, 64'(AccumReset), 64'd0);
        check({tag, ":s_done"}, 64'(WindowDone), 64'd0);
        check({tag, ":s_ready"}, 64'(LoadReady), 64'd0);
        if (h == 0) dsum += longint'(signed'(ProdOut));
        if (n == abort_at) begin
          LoadValid = 1'b0;
          #2;
          Reset = 1'b1;
          #1;
          check_reset_outs({tag, ":rst"});
          step();
          Reset = 1'b0;
          repeat (TAPS * HOLD + 3) begin
            step();
            check({tag, ":ab_done"}, 64'(WindowDone), 64'd0);
            check({tag, ":ab_valid"}, 64'(ProdValid), 64'd0);
            check({tag, ":ab_ready"}, 64'(LoadReady), 64'd1);
          end
          return;
        end
      end
    end
    step();
    check({tag, ":done"}, 64'(WindowDone), 64'd1);
    check({tag, ":d_valid"}, 64'(ProdValid), 64'd0);
    check({tag, ":d_prod"}, 64'(ProdOut), 64'd0);
    check({tag, ":d_ready"}, 64'(LoadReady), 64'd0);
    LoadValid = 1'b0;
    step();
    check({tag, ":ready_back"}, 64'(LoadReady), 64'd1);
    check({tag, ":done_pulse"}, 64'(WindowDone), 64'd0);
    check({tag, ":sum"}, 64'(dsum), 64'(msum));
  endtask

  initial begin
    #1 Reset = 1'b1;
    #2;
    check_reset_outs("reset");
    repeat (2) step();
    Reset = 1'b0;
    step();
    check_reset_outs("post_reset");

    for (int i = 0; i < TAPS; i++) begin
      tp[i] = i + 1;
      tw[i] = 1;
    end
    run_window("ones", -1);

    // No further window may start without fresh loads.
    repeat (6) begin
      step();
      check("quiet_clr", 64'(AccumReset), 64'd0);
      check("quiet_valid", 64'(ProdValid), 64'd0);
    end

    for (int i = 0; i < TAPS; i++) begin
      tp[i] = rnd_s16();
      tw[i] = rnd_s16();
    end
    tp[0] = -3;
    tw[0] = 5;
    run_window("neg", -1);

    for (int i = 0; i < TAPS; i++) begin
      tp[i] = (i % 2 == 0) ? -32768 : 32767;
      tw[i] = (i % 3 == 0) ? -32768 : 32767;
    end
    run_window("extreme", -1);

    for (int i = 0; i < TAPS; i++) begin
      tp[i] = rnd_s16();
      tw[i] = 0;
    end
    run_window("zero_w", -1);

    // Partial load abandoned by reset.
    for (int i = 0; i < 4; i++) begin
      LoadValid = 1'b1;
      LoadPixel = DATA_W'($urandom);
      step();
    end
    #2;
    Reset = 1'b1;
    #1;
    check_reset_outs("rst_load");
    step();
    Reset = 1'b0;
    LoadValid = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      tp[i] = rnd_s16();
      tw[i] = rnd_s16();
    end
    run_window("after_rst_load", -1);

    run_window("abort", 7);
    for (int i = 0; i < TAPS; i++) tp[i] = rnd_s16();
    run_window("after_abort", -1);

`ifdef CONV_TAP_ZERO_SKIP_EN
    for (int i = 0; i < TAPS; i++) begin
      tp[i] = 10;
      tw[i] = 0;
    end
    tw[2] = 4;
    tw[7] = -1;
    run_window("skip", -1);
`endif

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < TAPS; i++) begin
        tp[i] = rnd_s16();
        tw[i] = ($urandom_range(0, 2) == 0) ? 0 : rnd_s16();
      end
      run_window("rand", -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_tap_sequencer.md
# conv_tap_sequencer

Upstream feeder for the convolution accumulator. Buffers one kernel window of pixel/weight pairs, then streams their signed products one at a time on a 32-bit bus. Each product is held long enough for an alternate-cycle accumulator to sample it. Frames every window with a one-cycle accumulator-clear pulse before the first product and a done pulse after the last.

## Interface
- `DATA_W`, default 16: signed pixel and weight width.
- `TAPS`, default 9: pairs per window (3x3 kernel).
- `OUT_W`, default 32: product bus width; must be ≥ 2*DATA_W.
- `HOLD`, default 2: cycles each product stays on the bus; must be ≥ 1.

Ports:
- `Clk`  in  1  single clock; all state on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `LoadValid`  in  1  a pixel/weight pair is presented.
- `LoadPixel`  in  DATA_W  signed pixel.
- `LoadWeight`  in  DATA_W  signed weight.
- `LoadReady`  out  1  sequencer accepts pairs; a pair is taken when `LoadValid & LoadReady`.
- `AccumReset`  out  1  one-cycle clear pulse for the downstream accumulator.
- `ProdOut`  out  OUT_W  current product, sign-extended.
- `ProdValid`  out  1  `ProdOut` holds a live product.
- `WindowDone`  out  1  one-cycle pulse after the last product of the window.

## Operation
- Storage: TAPS-entry pixel buffer and TAPS-entry weight buffer.
  - Load index `LIdx`, 0..TAPS-1.
  - Stream index `SIdx`.
  - Hold counter `HCnt`, 0..HOLD-1.
- FSM states: IDLE, CLEAR, STREAM, DONE.
- IDLE
  - `LoadReady`=1.
  - Each accepted pair is written at `LIdx`, then `LIdx`++.
  - The accept at `LIdx`=TAPS-1 moves to CLEAR and wraps `LIdx` to 0.
- CLEAR
  - Lasts exactly one cycle.
  - `AccumReset`=1, `LoadReady`=0.
  - Sets `SIdx`=0 and loads the product of tap 0 into the output register; then moves to STREAM.
- STREAM
  - `ProdValid`=1, `LoadReady`=0.
  - `HCnt` counts 0..HOLD-1.
  - At `HCnt`=HOLD-1, the output register loads the next tap's product and `SIdx`++.
  - After the last tap's final hold cycle, moves to DONE.
- DONE
  - Lasts exactly one cycle.
  - `WindowDone`=1, `ProdValid`=0, `ProdOut`=0.
  - Returns to IDLE.
- Arithmetic: full signed DATA_W×DATA_W product, sign-extended to OUT_W. No truncation or saturation.
- `ProdOut` is forced to 0 whenever `ProdValid`=0.
- `LoadValid` outside IDLE is ignored; buffer contents are unchanged.
- Buffers are not cleared between windows. Every window requires a full TAPS loads.

## Timing
- Reset values:
  - `LoadReady`=1 (state IDLE).
  - `AccumReset`=0, `ProdOut`=0, `ProdValid`=0, `WindowDone`=0.
  - `LIdx`=`SIdx`=`HCnt`=0.
- Reset takes effect immediately and asynchronously. When asserted mid-load or mid-stream, the window is abandoned and the partial `LIdx` is discarded. No `WindowDone` is emitted. Buffer contents are don't-care.
- All outputs are registered.
- Let C be the cycle in which `AccumReset`=1; C is the cycle after the final accepted load.
  - Product k (0-based) is valid in cycles C+1+k*HOLD through C+(k+1)*HOLD.
  - `WindowDone` is high in cycle C+1+TAPS*HOLD.
  - `LoadReady` returns in cycle C+2+TAPS*HOLD.
- Minimum window period: TAPS + 2 + TAPS*HOLD cycles (29 at defaults).
- `AccumReset` and `ProdValid` are never high in the same cycle.
- `WindowDone` and `ProdValid` are never high in the same cycle.

## Configuration
- `CONV_TAP_ZERO_SKIP_EN` undefined:
  - All TAPS products are streamed, including zero-weight taps.
  - Timing is fixed as given above.
- `CONV_TAP_ZERO_SKIP_EN` defined:
  - In CLEAR and at each advance, the sequencer skips forward to the next tap with a non-zero weight. The skip is combinational and costs no cycles.
  - Only non-zero-weight taps occupy HOLD cycles.
  - With N non-zero taps, `WindowDone` is at C+1+N*HOLD.
  - If N=0, the cycle after CLEAR is DONE and `ProdValid` never rises.

## Test plan
- Defaults; load pixels 1..9 with all weights 1 → `AccumReset` at C; `ProdOut` = 1,1,2,2,…,9,9 over C+1..C+18; `WindowDone` at C+19; downstream sum is 45.
- Pixel −3, weight 5 at tap 0 → `ProdOut`=0xFFFFFFF1 in C+1..C+2.
- Pixel −32768, weight −32768 → `ProdOut`=0x40000000.
- `LoadValid`=1 with new data throughout STREAM → `LoadReady`=0, buffer unchanged; a second window with no reload is impossible until 9 fresh loads are accepted.
- `Reset` pulsed at C+7 → all outputs 0 and `LoadReady`=1 on release; no `WindowDone`; the next window starts only after 9 loads.
- With `CONV_TAP_ZERO_SKIP_EN`, weights zero except tap 2 (=4) and tap 7 (=−1), pixels all 10 → `ProdOut` 40,40 then 0xFFFFFFF6 twice; `WindowDone` at C+5.
